// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter with fixed priority display > clear > CPU.
// The hardware clear sequencer is compiled in only when FB_ARBITER_CLEAR_EN is defined.
module fb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        hires,
    input  logic        dispRd,
    input  logic [8:0]  dispAddr,
    output logic [15:0] dispData,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [8:0]  cpuAddr,
    input  logic [15:0] cpuWData,
    output logic [15:0] cpuRData,
    output logic        cpuAck,
    input  logic        clrReq,
    output logic        clrBusy,
    output logic [8:0]  memAddr,
    output logic        memWe,
    output logic [15:0] memWData,
    input  logic [15:0] memRData
);
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUED, ACK} cpu_state_e;

    cpu_state_e        state_q;
    logic              cpu_we_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              disp_vld_p1;
    logic [DATA_W-1:0] disp_data_q;

    logic              clr_hold;
    logic              clr_grant;
    logic [ADDR_W-1:0] clr_addr;
    logic              cpu_grant;

`ifdef FB_ARBITER_CLEAR_EN
    logic              clr_pend_q, clr_pend_d;
    logic              clr_act_q, clr_act_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] clr_last_q, clr_last_d;

    // A pending or running clear locks the CPU out of the RAM.
    assign clr_hold  = clr_pend_q | clr_act_q;
    assign clr_grant = clr_act_q & ~dispRd & ~reset;
    assign clr_addr  = clr_cnt_q;
    assign clrBusy   = clr_hold;

    always_comb begin
        clr_pend_d = clr_pend_q;
        clr_act_d  = clr_act_q;
        clr_cnt_d  = clr_cnt_q;
        clr_last_d = clr_last_q;
        if (clrReq && !clr_pend_q && !clr_act_q) begin
            clr_pend_d = 1'b1;
        end
        if (clr_pend_q && state_q == IDLE) begin
            clr_pend_d = 1'b0;
            clr_act_d  = 1'b1;
            clr_cnt_d  = '0;
            clr_last_d = hires ? 9'd511 : 9'd127;
        end
        if (clr_grant) begin
            if (clr_cnt_q == clr_last_q) begin
                clr_act_d = 1'b0;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_pend_q <= 1'b0;
            clr_act_q  <= 1'b0;
            clr_cnt_q  <= '0;
        end else begin
            clr_pend_q <= clr_pend_d;
            clr_act_q  <= clr_act_d;
            clr_cnt_q  <= clr_cnt_d;
        end
        clr_last_q <= clr_last_d;
    end
`else
    logic unused_clr;

    assign unused_clr = clrReq ^ hires;
    assign clr_hold   = 1'b0;
    assign clr_grant  = 1'b0;
    assign clr_addr   = '0;
    assign clrBusy    = 1'b0;
`endif

    assign cpu_grant = cpuReq & ~dispRd & ~clr_hold & ~reset & (state_q == IDLE);

    always_comb begin
        memAddr  = '0;
        memWe    = 1'b0;
        memWData = '0;
        if (dispRd) begin
            memAddr = dispAddr;
        end else if (clr_grant) begin
            memAddr = clr_addr;
            memWe   = 1'b1;
        end else if (cpu_grant) begin
            memAddr  = cpuAddr;
            memWe    = cpuWe;
            memWData = cpuWData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_grant) begin
                        state_q  <= ISSUED;
                        cpu_we_q <= cpuWe;
                    end
                end
                ISSUED: begin
                    state_q   <= ACK;
                    cpu_ack_q <= 1'b1;
                    if (!cpu_we_q) begin
                        cpu_rdata_q <= memRData;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // p0 -> p1: RAM returns display data one cycle after the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_vld_p1 <= 1'b0;
            disp_data_q <= '0;
        end else begin
            disp_vld_p1 <= dispRd;
            if (disp_vld_p1) begin
                disp_data_q <= memRData;
            end
        end
    end

    assign dispData = disp_data_q;
    assign cpuRData = cpu_rdata_q;
    assign cpuAck   = cpu_ack_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized bench for fb_arbiter against a cycle-scheduled reference model.
// Clear-sequencer expectations follow FB_ARBITER_CLEAR_EN.
module tb_fb_arbiter;
    logic        clk = 1'b0;
    logic        reset, hires, dispRd, cpuReq, cpuWe, clrReq;
    logic        cpuAck, clrBusy, memWe;
    logic [8:0]  dispAddr, cpuAddr, memAddr;
    logic [15:0] dispData, cpuWData, cpuRData, memWData, memRData;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk(clk), .reset(reset), .hires(hires),
        .dispRd(dispRd), .dispAddr(dispAddr), .dispData(dispData),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuRData(cpuRData), .cpuAck(cpuAck),
        .clrReq(clrReq), .clrBusy(clrBusy),
        .memAddr(memAddr), .memWe(memWe), .memWData(memWData), .memRData(memRData)
    );

    // Synchronous read-first RAM behind the arbiter, preloadable from the bench.
    logic [15:0] ram [0:511];
    logic        pre_en;
    logic [8:0]  pre_addr;
    logic [15:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (memWe) ram[memAddr] <= memWData;
        memRData <= ram[memAddr];
    end

`ifdef FB_ARBITER_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    // Reference model: expected RAM image plus scheduled completion cycles.
    logic [15:0] ref_mem [0:511];
    int          cyc, m_ack_at, m_rd_at, m_caddr, m_len;
    logic [15:0] m_rd_val, exp_disp, exp_rd, disp_val;
    bit          disp_pend, m_pend, m_active;
    int          n_vec, n_err;

    int          p_disp, p_cpu, p_clr, force_disp;
    bit          alt_disp, hires_rnd, hires_v, rst_v, rst_rnd, clr_pulse;
    bit          cpu_out, cpu_force;
    logic        cpu_f_we;
    logic [8:0]  cpu_f_addr;
    logic [15:0] cpu_f_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic run_cycle();
        bit idle, cpug, clrw, pend0, act0;
        @(posedge clk);
        #1;
        cyc++;
        check_val("cpuAck", 32'(cpuAck), 32'(cyc == m_ack_at));
        check_val("dispData", 32'(dispData), 32'(exp_disp));
        check_val("cpuRData", 32'(cpuRData), 32'(exp_rd));
        check_val("clrBusy", 32'(clrBusy), 32'(m_pend || m_active));

        reset = rst_v || (rst_rnd && $urandom_range(999) < 2);
        hires = hires_rnd ? 1'($urandom_range(1)) : hires_v;
        if (force_disp >= 0) dispRd = force_disp[0];
        else if (alt_disp) dispRd = cyc[0];
        else dispRd = ($urandom_range(99) < p_disp);
        dispAddr = 9'($urandom);
        if (!cpu_out) begin
            if (cpu_force) begin
                cpu_out = 1; cpu_force = 0;
                cpuWe = cpu_f_we; cpuAddr = cpu_f_addr; cpuWData = cpu_f_data;
            end else if ($urandom_range(99) < p_cpu) begin
                cpu_out = 1;
                cpuWe = 1'($urandom_range(1));
                cpuAddr = ($urandom_range(1) == 1) ? 9'($urandom_range(15)) : 9'($urandom);
                cpuWData = 16'($urandom);
            end
        end
        cpuReq = cpu_out;
        clrReq = clr_pulse || ($urandom_range(999) < p_clr);
        clr_pulse = 0;
        #1;

        idle  = (cyc > m_ack_at);
        pend0 = m_pend;
        act0  = m_active;
        cpug  = !reset && !dispRd && idle && cpuReq && !m_pend && !m_active;
        clrw  = !reset && m_active && !dispRd;
        if (reset) begin
            check_val("memWe_rst", 32'(memWe), 32'd0);
        end else if (dispRd) begin
            check_val("memWe_disp", 32'(memWe), 32'd0);
            check_val("memAddr_disp", 32'(memAddr), 32'(dispAddr));
        end else if (clrw) begin
            check_val("memWe_clr", 32'(memWe), 32'd1);
            check_val("memAddr_clr", 32'(memAddr), 32'(m_caddr));
            check_val("memWData_clr", 32'(memWData), 32'd0);
        end else if (cpug) begin
            check_val("memWe_cpu", 32'(memWe), 32'(cpuWe));
            check_val("memAddr_cpu", 32'(memAddr), 32'(cpuAddr));
            if (cpuWe) check_val("memWData_cpu", 32'(memWData), 32'(cpuWData));
        end else begin
            check_val("memWe_idle", 32'(memWe), 32'd0);
        end

        if (reset) begin
            m_pend = 0; m_active = 0; m_caddr = 0;
            exp_disp = '0; exp_rd = '0; disp_pend = 0;
            m_ack_at = -10; m_rd_at = -10; cpu_out = 0;
        end else begin
            if (disp_pend) exp_disp = disp_val;
            disp_pend = dispRd;
            if (dispRd) disp_val = ref_mem[dispAddr];
            if (cyc == m_rd_at) exp_rd = m_rd_val;
            if (cyc == m_ack_at) cpu_out = 0;
            if (cpug) begin
                m_ack_at = cyc + 2;
                if (cpuWe) ref_mem[cpuAddr] = cpuWData;
                else begin
                    m_rd_val = ref_mem[cpuAddr];
                    m_rd_at = cyc + 1;
                end
            end
            if (CLR_EN) begin
                if (clrw) begin
                    ref_mem[m_caddr] = '0;
                    m_caddr++;
                    if (m_caddr == m_len) begin
                        m_active = 0;
                        m_caddr = 0;
                    end
                end
                if (pend0 && idle) begin
                    m_pend = 0; m_active = 1; m_caddr = 0;
                    m_len = hires ? 512 : 128;
                end
                if (clrReq && !pend0 && !act0) m_pend = 1;
            end
        end
    endtask

    task automatic quiet();
        p_disp = 0; p_cpu = 0; p_clr = 0; force_disp = -1;
        alt_disp = 0; hires_rnd = 0; rst_rnd = 0; rst_v = 0;
    endtask

    task automatic drain();
        bit ok;
        quiet();
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            run_cycle();
            ok = !cpu_out && !m_pend && !m_active;
        end
        check_val("drain_done", 32'(ok), 32'd1);
        run_cycle();
        run_cycle();
    endtask

    task automatic cpu_directed(input logic we, input logic [8:0] a, input logic [15:0] d);
        int t0, seen;
        cpu_f_we = we; cpu_f_addr = a; cpu_f_data = d; cpu_force = 1;
        run_cycle();
        t0 = cyc;
        seen = -1;
        for (int i = 0; i < 8 && seen < 0; i++) begin
            run_cycle();
            if (cpuAck) seen = cyc;
        end
        check_val("ack_latency", 32'(seen - t0), 32'd2);
    endtask

    task automatic clear_run(input bit hr, input bit alt, output int busy, output int wr,
                             output int bad, output bit done);
        hires_v = hr; alt_disp = alt; clr_pulse = 1;
        busy = 0; wr = 0; bad = 0; done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            run_cycle();
            if (clrBusy) busy++;
            else if (busy > 0) done = 1;
            if (memWe) begin
                wr++;
                if (memWData != 16'h0 || (!hr && memAddr >= 9'h080)) bad++;
            end
        end
        alt_disp = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy, wr, bad, nack;
        bit done;
        n_vec = 0; n_err = 0; cyc = 0;
        m_ack_at = -10; m_rd_at = -10; m_caddr = 0; m_len = 128;
        m_pend = 0; m_active = 0; disp_pend = 0;
        exp_disp = '0; exp_rd = '0; disp_val = '0; m_rd_val = '0;
        cpu_out = 0; cpu_force = 0; clr_pulse = 0; hires_v = 0;
        cpu_f_we = 0; cpu_f_addr = '0; cpu_f_data = '0;
        reset = 1; hires = 0; dispRd = 0; dispAddr = '0; cpuReq = 0; cpuWe = 0;
        cpuAddr = '0; cpuWData = '0; clrReq = 0;
        quiet();
        rst_v = 1; force_disp = 0; pre_en = 1;
        for (int a = 0; a < 512; a++) begin
            pre_addr = 9'(a);
            pre_data = 16'($urandom);
            ref_mem[a] = pre_data;
            run_cycle();
        end
        pre_en = 0;
        run_cycle();
        drain();

        // CPU write then read-back on an idle bus.
        cpu_directed(1'b1, 9'h005, 16'h1234);
        cpu_directed(1'b0, 9'h005, 16'h0000);
        check_val("rd_back_0x005", 32'(cpuRData), 32'h1234);

        // Display held for 4 cycles starves a waiting CPU request.
        drain();
        cpu_f_we = 0; cpu_f_addr = 9'h0A3; cpu_f_data = '0; cpu_force = 1;
        force_disp = 1; nack = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (cpuAck) nack++;
        end
        check_val("ack_during_disp", 32'(nack), 32'd0);
        force_disp = 0; nack = 0;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            if (cpuAck) nack++;
        end
        check_val("ack_after_disp", 32'(nack), 32'd1);

`ifdef FB_ARBITER_CLEAR_EN
        drain();
        clear_run(1'b0, 1'b0, busy, wr, bad, done);
        check_val("clr_lo_done", 32'(done), 32'd1);
        check_val("clr_lo_writes", 32'(wr), 32'd128);
        check_val("clr_lo_busy", 32'(busy), 32'd129);
        check_val("clr_lo_bad", 32'(bad), 32'd0);

        drain();
        clear_run(1'b1, 1'b1, busy, wr, bad, done);
        check_val("clr_hi_done", 32'(done), 32'd1);
        check_val("clr_hi_writes", 32'(wr), 32'd512);
        check_val("clr_hi_busy_range", 32'(busy >= 1020 && busy <= 1030), 32'd1);
        check_val("clr_hi_bad", 32'(bad), 32'd0);

        // Clear requested while a CPU read is in flight.
        drain();
        hires_v = 0;
        cpu_f_we = 0; cpu_f_addr = 9'h010; cpu_f_data = '0; cpu_force = 1;
        run_cycle();
        clr_pulse = 1;
        run_cycle();
        cpu_f_we = 1; cpu_f_addr = 9'h011; cpu_f_data = 16'hBEEF; cpu_force = 1;
        run_cycle();
        check_val("ack_before_clr", 32'(cpuAck), 32'd1);
        check_val("busy_at_ack", 32'(clrBusy), 32'd1);
        nack = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            run_cycle();
            if (cpuAck && clrBusy) nack++;
            done = !clrBusy;
        end
        check_val("cpu_blocked_in_clr", 32'(nack), 32'd0);
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            if (cpuAck) nack++;
        end
        check_val("cpu_after_clr", 32'(nack), 32'd1);

        // Reset in the cycle that would write counter 0x040.
        drain();
        hires_v = 0; clr_pulse = 1; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            run_cycle();
            done = memWe && memAddr == 9'h03F;
        end
        check_val("reach_0x03F", 32'(done), 32'd1);
        rst_v = 1;
        run_cycle();
        rst_v = 0;
        run_cycle();
        check_val("busy_after_rst", 32'(clrBusy), 32'd0);
        wr = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            if (memWe) wr++;
        end
        check_val("writes_after_rst", 32'(wr), 32'd0);
        clear_run(1'b0, 1'b0, busy, wr, bad, done);
        check_val("clr_after_rst_writes", 32'(wr), 32'd128);
`else
        drain();
        clr_pulse = 1; wr = 0; busy = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            if (memWe) wr++;
            if (clrBusy) busy++;
        end
        check_val("noclr_writes", 32'(wr), 32'd0);
        check_val("noclr_busy", 32'(busy), 32'd0);
`endif

        // Mixed random traffic with occasional clears, hires toggling and resets.
        drain();
        p_disp = 30; p_cpu = 50; p_clr = 2; hires_rnd = 1; rst_rnd = 1;
        for (int i = 0; i < 4000; i++) run_cycle();
        p_disp = 70; p_cpu = 90; p_clr = 1; rst_rnd = 0;
        for (int i = 0; i < 2000; i++) run_cycle();
        drain();

        for (int a = 0; a < 512; a++) check_val("ram_image", 32'(ram[a]), 32'(ref_mem[a]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: single clock for all logic.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port hires, input, 1: selects the clear range, 512 words when high and 128 words when low.
REQ-004 SHALL have port dispRd, input, 1: display read request for the current cycle.
REQ-005 SHALL have port dispAddr, input, 9: display word address.
REQ-006 SHALL have port dispData, output, 16: registered data from the last display read.
REQ-007 SHALL have port cpuReq, input, 1: CPU access request, held high until cpuAck.
REQ-008 SHALL have port cpuWe, input, 1: CPU access is a write (1) or read (0).
REQ-009 SHALL have port cpuAddr, input, 9: CPU word address.
REQ-010 SHALL have port cpuWData, input, 16: CPU write data.
REQ-011 SHALL have port cpuRData, output, 16: registered CPU read data.
REQ-012 SHALL have port cpuAck, output, 1: one-cycle completion pulse for a CPU access.
REQ-013 SHALL have port clrReq, input, 1: pulse requesting a hardware clear of the framebuffer.
REQ-014 SHALL have port clrBusy, output, 1: clear is pending or in progress.
REQ-015 SHALL have port memAddr, output, 9: RAM address.
REQ-016 SHALL have port memWe, output, 1: RAM write enable.
REQ-017 SHALL have port memWData, output, 16: RAM write data.
REQ-018 SHALL have port memRData, input, 16: RAM read data, valid one cycle after its address.

Function
REQ-019 SHALL grant the RAM each cycle with fixed priority: display (dispRd) first, then clear, then CPU.
REQ-020 SHALL drive memAddr/memWe/memWData combinationally from the granted owner, and drive memWe=0 when the display is granted or no owner is granted.
REQ-021 SHALL never stall a display read: for dispRd in cycle N, dispData SHALL update at the end of cycle N+1 and hold until the next display read.
REQ-022 SHALL sequence CPU accesses with FSM states IDLE, ISSUED and ACK.
REQ-023 SHALL grant the CPU only in IDLE when cpuReq=1, dispRd=0 and no clear is pending or active, and SHALL then move to ISSUED.
REQ-024 SHALL always move ISSUED->ACK; in ISSUED it SHALL capture memRData into cpuRData on reads, and leave cpuRData unchanged on writes.
REQ-025 SHALL assert cpuAck in ACK (cycle N+2 after the grant) for reads and writes alike, then return to IDLE.
REQ-026 SHALL not grant a new CPU access during ISSUED or ACK, and the requester SHALL deassert cpuReq or present a new request in the cycle after cpuAck.
REQ-027 SHALL latch clrReq as pending in any state, raise clrBusy on the following cycle, and ignore clrReq while pending or active.
REQ-028 SHALL start a clear only in IDLE, so an in-flight CPU access completes first.
REQ-029 SHALL sample hires at clear start to set the last address to 511 (hires) or 127 (lores), and ignore later hires changes.
REQ-030 SHALL, while clearing, write 0x0000 to the counter address on every cycle without dispRd, incrementing the counter on each such write.
REQ-031 SHALL drop clrBusy the cycle after the write to the last address, and return the counter to 0.
REQ-032 SHALL use 9-bit wrapping addresses with no range checking of dispAddr or cpuAddr.

Reset
REQ-033 SHALL, with reset high at a clk edge, set the FSM to IDLE, the clear counter, pending flag, dispData, cpuRData, cpuAck and clrBusy to 0, and memWe to 0 while reset is held.
REQ-034 SHALL abort any clear or CPU access in progress on reset mid-operation, with no cpuAck issued for it.

Configuration
REQ-035 SHALL compile in the clear sequencer (REQ-027..REQ-031) only when macro FB_ARBITER_CLEAR_EN is defined.
REQ-036 SHALL, without FB_ARBITER_CLEAR_EN, ignore clrReq, tie clrBusy to 0 and give the CPU priority directly below the display.

Verification
REQ-037 SHALL cover: CPU write 0x1234 @0x005 with idle display -> memWe=1 in the grant cycle, cpuAck 2 cycles later, then a read of 0x005 returns cpuRData=0x1234.
REQ-038 SHALL cover: dispRd held high for 4 cycles while cpuReq is high -> no CPU grant until dispRd drops, and dispData tracks each address with 1-cycle latency.
REQ-039 SHALL cover: clrReq with hires=0 and no display traffic -> exactly 128 zero writes to 0x000..0x07F, clrBusy high for 129 cycles, and words >=0x080 untouched.
REQ-040 SHALL cover: clrReq with hires=1 and dispRd on every 2nd cycle -> 512 zero writes, clear stretched to about 1024 cycles, and display reads unaffected.
REQ-041 SHALL cover: clrReq while a CPU read is ISSUED -> cpuAck delivered first, clear begins in the next IDLE, and cpuReq is blocked until clrBusy=0.
REQ-042 SHALL cover: reset asserted mid-clear at counter 0x040 -> clrBusy=0 and counter=0 the next cycle, and no further writes occur.
